cpu6_ifu: RTL
=============

CPU6_IFU -- requirements
Module: cpu6_ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single core clock; every register updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_req  output  1  fetch request valid.
REQ-005 imem_addr  output  32  fetch address, word aligned.
REQ-006 imem_ack  input  1  instruction memory returns imem_rdata this cycle for the outstanding request.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 redirect_valid  input  1  taken branch/jump from EX (pcsrcE).
REQ-009 redirect_pc  input  32  redirect target (pcnextE).
REQ-010 excp_valid  input  1  trap entry request.
REQ-011 csr_mtvec  input  32  trap vector.
REQ-012 mret_ena  input  1  return from trap.
REQ-013 csr_mepc  input  32  return address.
REQ-014 stallF  input  1  downstream cannot accept a new instruction.
REQ-015 empty_pipeline_reqE  input  1  drain request; freezes fetch.
REQ-016 empty_pipeline_ackW  input  1  drain complete.
REQ-017 instr_validE  output  1  pcE/instrE hold a live instruction.
REQ-018 pcE  output  32  PC of the presented instruction.
REQ-019 instrE  output  32  presented instruction; 32'h0000_0013 (NOP) when not valid.

Function
REQ-020 FSM states SHALL be IDLE, REQ, HOLD and DRAIN.
REQ-021 IDLE SHALL last exactly one cycle after reset and then go to REQ with fetch_pc=RESET_PC.
REQ-022 In REQ, imem_req=1 and imem_addr=fetch_pc, held stable until imem_ack.
REQ-023 On imem_ack in REQ with no kill, the block SHALL register instrE=imem_rdata, pcE=fetch_pc, instr_validE=1 and set fetch_pc+=4, so ack-to-output latency is 1 cycle.
REQ-024 After the ack, if stallF=0 the FSM SHALL stay in REQ and issue the next request the following cycle; if stallF=1 it SHALL go to HOLD.
REQ-025 In HOLD, imem_req=0 and outputs SHALL be frozen; on stallF=0 the FSM SHALL return to REQ.
REQ-026 Next-PC priority SHALL be excp_valid (csr_mtvec) > mret_ena (csr_mepc) > redirect_valid (redirect_pc) > sequential fetch_pc+4.
REQ-027 On any redirect, fetch_pc SHALL load the selected target and instr_validE SHALL clear next cycle, which flushes the presented instruction.
REQ-028 A redirect while a request is outstanding SHALL set a kill flag; the matching imem_ack data SHALL be discarded and the new address requested the cycle after that ack.
REQ-029 A redirect coincident with imem_ack SHALL discard that ack's data.
REQ-030 Redirect wins over stallF; a redirect in HOLD goes to REQ.
REQ-031 empty_pipeline_reqE=1 SHALL move the FSM to DRAIN once no request is outstanding: imem_req=0, instr_validE=0, fetch_pc retained.
REQ-032 In DRAIN, empty_pipeline_ackW=1 SHALL return the FSM to REQ.
REQ-033 A redirect in DRAIN SHALL update fetch_pc without leaving DRAIN.
REQ-034 fetch_pc SHALL wrap modulo 2^32, so 32'hFFFF_FFFC+4=0.
REQ-035 Redirect targets SHALL have bits [1:0] forced to 0.

Reset
REQ-036 While reset=1: state=IDLE, imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC, kill=0, instr_validE=0, pcE=RESET_PC, instrE=NOP.
REQ-037 Reset asserted mid-request SHALL abandon the request; an imem_ack arriving during reset or in IDLE SHALL be ignored.

Structure
REQ-038 FSM state encodings, the NOP constant and the 4-byte PC increment SHALL live in the shared defines file, alongside CPU6_XLEN.
REQ-039 The next-PC priority selector SHALL be the single sub-module cpu6_ifu_pcsel (combinational); the FSM, fetch_pc, kill flag and output registers stay in cpu6_ifu.

Verification
REQ-040 Reset release, imem_ack tied 1, rdata=addr -> addresses 0,4,8 requested in consecutive cycles; pcE/instrE track them with 1-cycle latency.
REQ-041 stallF=1 for 3 cycles after ack at 0x8 -> imem_req=0, pcE=0x8 held; stallF=0 -> request 0xC.
REQ-042 Redirect to 0x100 while ack pending (ack delayed 2 cycles) -> stale data dropped, instr_validE=0, next request 0x100.
REQ-043 excp_valid, mret_ena and redirect_valid in the same cycle, mtvec=0x80 -> next request 0x80.
REQ-044 empty_pipeline_reqE pulse -> DRAIN, no requests for 5 cycles; empty_pipeline_ackW -> resumes at retained fetch_pc.
REQ-045 Redirect to 0xFFFF_FFFC, sequential fetch -> next request 0x0000_0000.

Source files
------------

// File: rtl/cpu6_ifu_pkg.sv
// Shared definitions for the cpu6 instruction fetch unit: datapath width,
// fetch FSM encodings, the NOP filler word and the sequential PC step.
package cpu6_ifu_pkg;

   localparam int CPU6_XLEN = 32;

   // Canonical RISC-V NOP (addi x0, x0, 0), presented when no instruction is live.
   localparam logic [CPU6_XLEN-1:0] CPU6_NOP = 32'h0000_0013;

   // Byte distance between consecutive instruction words.
   localparam logic [CPU6_XLEN-1:0] CPU6_PC_INC = 32'd4;

   // Fetch FSM states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } ifuState_t;

endpackage

// File: rtl/cpu6_ifu_pcsel.sv
// Next-PC selector: trap entry beats trap return beats EX redirect beats
// sequential fetch. Redirect targets are forced word aligned.
module cpu6_ifu_pcsel
   import cpu6_ifu_pkg::*;
(
   input  logic                 excp_valid,
   input  logic [CPU6_XLEN-1:0] csr_mtvec,
   input  logic                 mret_ena,
   input  logic [CPU6_XLEN-1:0] csr_mepc,
   input  logic                 redirect_valid,
   input  logic [CPU6_XLEN-1:0] redirect_pc,
   input  logic [CPU6_XLEN-1:0] fetchPc,
   output logic                 redirValid,
   output logic [CPU6_XLEN-1:0] nextPc
);

   logic [CPU6_XLEN-1:0] target;

   // Priority mux over the redirect sources, then fall back to fetchPc + 4 (wraps mod 2^32).
   always_comb begin
      target = redirect_pc;
      if (excp_valid) begin
         target = csr_mtvec;
      end else if (mret_ena) begin
         target = csr_mepc;
      end
      redirValid = excp_valid | mret_ena | redirect_valid;
      if (redirValid) begin
         nextPc = {target[CPU6_XLEN-1:2], 2'b00};
      end else begin
         nextPc = fetchPc + CPU6_PC_INC;
      end
   end

endmodule

// File: rtl/cpu6_ifu.sv
// cpu6 instruction fetch unit. Issues one instruction-memory request at a
// time and presents the returned word to EX one cycle after the ack.
//
// Handshake: imem_req/imem_addr form a request that stays asserted with a
// stable address until imem_ack; imem_ack returns imem_rdata in that same
// cycle and retires the request. A redirect during an outstanding request
// cannot withdraw it, so the request keeps its old address (killAddr) and
// its data is dropped when the ack arrives; the new target is requested on
// the following cycle. instr_validE is the only qualifier on pcE/instrE.
module cpu6_ifu
   import cpu6_ifu_pkg::*;
#(
   parameter logic [CPU6_XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic                 imem_req,
   output logic [CPU6_XLEN-1:0] imem_addr,
   input  logic                 imem_ack,
   input  logic [CPU6_XLEN-1:0] imem_rdata,
   input  logic                 redirect_valid,
   input  logic [CPU6_XLEN-1:0] redirect_pc,
   input  logic                 excp_valid,
   input  logic [CPU6_XLEN-1:0] csr_mtvec,
   input  logic                 mret_ena,
   input  logic [CPU6_XLEN-1:0] csr_mepc,
   input  logic                 stallF,
   input  logic                 empty_pipeline_reqE,
   input  logic                 empty_pipeline_ackW,
   output logic                 instr_validE,
   output logic [CPU6_XLEN-1:0] pcE,
   output logic [CPU6_XLEN-1:0] instrE,
   output ifuState_t            dbgState
);

   ifuState_t            state, stateNxt;
   logic [CPU6_XLEN-1:0] fetchPc, fetchPcNxt;
   logic                 kill, killNxt;
   logic [CPU6_XLEN-1:0] killAddr, killAddrNxt;
   logic                 validReg, validNxt;
   logic [CPU6_XLEN-1:0] pcReg, pcNxt;
   logic [CPU6_XLEN-1:0] instrReg, instrNxt;
   logic                 redirValid;
   logic [CPU6_XLEN-1:0] nextPc;

   cpu6_ifu_pcsel u_pcsel (
      .excp_valid     (excp_valid),
      .csr_mtvec      (csr_mtvec),
      .mret_ena       (mret_ena),
      .csr_mepc       (csr_mepc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetchPc        (fetchPc),
      .redirValid     (redirValid),
      .nextPc         (nextPc)
   );

   // State, fetch PC, kill tracking and EX-facing output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         fetchPc  <= RESET_PC;
         kill     <= 1'b0;
         killAddr <= RESET_PC;
         validReg <= 1'b0;
         pcReg    <= RESET_PC;
         instrReg <= CPU6_NOP;
      end else begin
         state    <= stateNxt;
         fetchPc  <= fetchPcNxt;
         kill     <= killNxt;
         killAddr <= killAddrNxt;
         validReg <= validNxt;
         pcReg    <= pcNxt;
         instrReg <= instrNxt;
      end
   end

   // Next-state and next-register logic; every path starts from "hold everything".
   always_comb begin
      stateNxt    = state;
      fetchPcNxt  = fetchPc;
      killNxt     = kill;
      killAddrNxt = killAddr;
      validNxt    = validReg;
      pcNxt       = pcReg;
      instrNxt    = instrReg;
      imem_req    = 1'b0;
      case (state)
         IDLE: begin
            // One settling cycle after reset; any stray ack here is ignored.
            stateNxt   = REQ;
            fetchPcNxt = RESET_PC;
         end
         REQ: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               killNxt = 1'b0;
               if (redirValid) begin
                  // Redirect coincident with the ack: data belongs to the old path.
                  fetchPcNxt = nextPc;
                  validNxt   = 1'b0;
                  instrNxt   = CPU6_NOP;
                  stateNxt   = empty_pipeline_reqE ? DRAIN : REQ;
               end else if (kill) begin
                  // Ack of a request issued before a redirect: drop it.
                  stateNxt = empty_pipeline_reqE ? DRAIN : REQ;
               end else if (empty_pipeline_reqE) begin
                  // Drop the word and keep fetchPc so it is refetched after the drain.
                  validNxt = 1'b0;
                  instrNxt = CPU6_NOP;
                  stateNxt = DRAIN;
               end else begin
                  validNxt   = 1'b1;
                  pcNxt      = fetchPc;
                  instrNxt   = imem_rdata;
                  fetchPcNxt = nextPc;
                  stateNxt   = stallF ? HOLD : REQ;
               end
            end else if (redirValid) begin
               // Request still outstanding: remember its address and kill its data.
               fetchPcNxt = nextPc;
               validNxt   = 1'b0;
               instrNxt   = CPU6_NOP;
               if (!kill) begin
                  killNxt     = 1'b1;
                  killAddrNxt = fetchPc;
               end
            end else if (!stallF) begin
               // Presented instruction was consumed and nothing new arrived.
               validNxt = 1'b0;
               instrNxt = CPU6_NOP;
            end
         end
         HOLD: begin
            if (redirValid) begin
               fetchPcNxt = nextPc;
               validNxt   = 1'b0;
               instrNxt   = CPU6_NOP;
               stateNxt   = REQ;
            end else if (empty_pipeline_reqE) begin
               validNxt = 1'b0;
               instrNxt = CPU6_NOP;
               stateNxt = DRAIN;
            end else if (!stallF) begin
               stateNxt = REQ;
            end
         end
         DRAIN: begin
            // Fetch frozen; redirects still steer where fetch resumes.
            validNxt = 1'b0;
            instrNxt = CPU6_NOP;
            if (redirValid) begin
               fetchPcNxt = nextPc;
            end
            if (empty_pipeline_ackW) begin
               stateNxt = REQ;
            end
         end
         default: begin
            stateNxt = IDLE;
         end
      endcase
   end

   // An outstanding killed request keeps presenting its original address.
   always_comb begin
      imem_addr = kill ? killAddr : fetchPc;
   end

   assign instr_validE = validReg;
   assign pcE          = pcReg;
   assign instrE       = instrReg;
   assign dbgState     = state;

endmodule
